// File: rtl/mac_accumulator_pkg.sv
// Shared constants and small helpers for the lane-segmented MAC accumulator.
// Lane grouping codes, default widths and vector-open FSM encodings live here.
package mac_accumulator_pkg;

    localparam logic [1:0] MAC_SINGLE = 2'd0;
    localparam logic [1:0] MAC_DUAL   = 2'd1;
    localparam logic [1:0] MAC_QUAD   = 2'd2;

    localparam int MAC_ACC_WIDTH = 16;
    localparam int MAC_INT_WIDTH = 8;
    localparam int MAC_MIN_WIDTH = 4;

    localparam logic [0:0] ST_FIRST = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    // Unknown grouping codes fall back to independent lanes.
    function automatic logic [1:0] norm_cfg(input logic [1:0] cfg);
        return (cfg == MAC_DUAL || cfg == MAC_QUAD) ? cfg : MAC_SINGLE;
    endfunction

    function automatic logic [3:0] group_top_mask(input logic [1:0] cfg);
        logic [3:0] mask;
        case (cfg)
            MAC_DUAL: mask = 4'b1010;
            MAC_QUAD: mask = 4'b1000;
            default:  mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// Beat-in / result-out bundle between the MAC combiner, the accumulator and
// the result writeback.
interface mac_accumulator_if #(
    parameter int ACC_W = mac_accumulator_pkg::MAC_ACC_WIDTH
) ();

    logic [1:0]       cfg;
    logic [ACC_W-1:0] in0, in1, in2, in3;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [ACC_W-1:0] acc0, acc1, acc2, acc3;
    logic [3:0]       ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output cfg, in0, in1, in2, in3, in_valid, in_last, out_ready,
        input  in_ready, acc0, acc1, acc2, acc3, ovf, out_valid
    );

    modport slave (
        input  cfg, in0, in1, in2, in3, in_valid, in_last, out_ready,
        output in_ready, acc0, acc1, acc2, acc3, ovf, out_valid
    );

endinterface

// File: rtl/mac_acc_lane.sv
// One accumulator lane: ACC_W adder with carry chain ports and a signed
// overflow flag that is meaningful only when this lane is a group top.
module mac_acc_lane #(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    input  logic             cin,
    output logic [ACC_W-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [ACC_W:0] full;
    logic           msb_cin;

    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{ACC_W{1'b0}}, cin};
    end

    assign sum  = full[ACC_W-1:0];
    assign cout = full[ACC_W];
    // Carry into the MSB recovered from the operand and result MSBs.
    assign msb_cin = a[ACC_W-1] ^ b[ACC_W-1] ^ sum[ACC_W-1];
    assign ovf     = msb_cin ^ cout;

endmodule

// File: rtl/mac_accumulator.sv
// Lane-segmented accumulator behind the MAC combiner: sums beats of a vector
// into four lanes (single/dual/quad carry grouping) and holds one result.
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int ACC_W = MAC_ACC_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    mac_accumulator_if.slave  bus
);

    logic [0:0]            open_q, open_d;
    logic [1:0]            cfg_q, cfg_d;
    logic [3:0][ACC_W-1:0] acc_reg_q, acc_reg_d;
    logic [3:0][ACC_W-1:0] acc_out_q, acc_out_d;
    logic [3:0]            ovf_acc_q, ovf_acc_d;
    logic [3:0]            ovf_q, ovf_d;
    logic                  out_valid_q, out_valid_d;

    logic                  in_ready, in_fire, out_fire;
    logic [1:0]            cfg_use;
    logic                  chained;
    logic [3:0][ACC_W-1:0] base, lane_in, lane_sum;
    logic [3:0]            lane_ovf, new_ovf;
    logic                  cout0, cout1, cout2, lane3_cout_unused;
    logic                  cin1, cin2, cin3;

    assign in_ready = en & (~out_valid_q | bus.out_ready);
    assign in_fire  = bus.in_valid & in_ready;
    assign out_fire = en & out_valid_q & bus.out_ready;

    // Grouping is frozen once a vector is open; the first beat uses live cfg.
    assign cfg_use = (open_q == ST_ACCUM) ? cfg_q : norm_cfg(bus.cfg);
    assign chained = (cfg_use != MAC_SINGLE);

    assign cin1 = chained & cout0;
    assign cin2 = (cfg_use == MAC_QUAD) & cout1;
    assign cin3 = chained & cout2;

    assign base    = (open_q == ST_ACCUM) ? acc_reg_q : '0;
    assign lane_in = {bus.in3, bus.in2, bus.in1, bus.in0};

    mac_acc_lane #(.ACC_W(ACC_W)) u_lane0 (
        .a(base[0]), .b(lane_in[0]), .cin(1'b0),
        .sum(lane_sum[0]), .cout(cout0), .ovf(lane_ovf[0])
    );
    mac_acc_lane #(.ACC_W(ACC_W)) u_lane1 (
        .a(base[1]), .b(lane_in[1]), .cin(cin1),
        .sum(lane_sum[1]), .cout(cout1), .ovf(lane_ovf[1])
    );
    mac_acc_lane #(.ACC_W(ACC_W)) u_lane2 (
        .a(base[2]), .b(lane_in[2]), .cin(cin2),
        .sum(lane_sum[2]), .cout(cout2), .ovf(lane_ovf[2])
    );
    mac_acc_lane #(.ACC_W(ACC_W)) u_lane3 (
        .a(base[3]), .b(lane_in[3]), .cin(cin3),
        .sum(lane_sum[3]), .cout(lane3_cout_unused), .ovf(lane_ovf[3])
    );

    assign new_ovf = lane_ovf & group_top_mask(cfg_use);

    always_comb begin
        open_d      = open_q;
        cfg_d       = cfg_q;
        acc_reg_d   = acc_reg_q;
        acc_out_d   = acc_out_q;
        ovf_acc_d   = ovf_acc_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (in_fire) begin
            if (open_q == ST_FIRST) begin
                cfg_d = norm_cfg(bus.cfg);
            end
            if (bus.in_last) begin
                acc_out_d   = lane_sum;
                ovf_d       = ovf_acc_q | new_ovf;
                out_valid_d = 1'b1;
                acc_reg_d   = '0;
                ovf_acc_d   = '0;
                open_d      = ST_FIRST;
            end else begin
                acc_reg_d   = lane_sum;
                ovf_acc_d   = ovf_acc_q | new_ovf;
                open_d      = ST_ACCUM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            open_q      <= ST_FIRST;
            cfg_q       <= MAC_SINGLE;
            acc_reg_q   <= '0;
            acc_out_q   <= '0;
            ovf_acc_q   <= '0;
            ovf_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            open_q      <= open_d;
            cfg_q       <= cfg_d;
            acc_reg_q   <= acc_reg_d;
            acc_out_q   <= acc_out_d;
            ovf_acc_q   <= ovf_acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.acc0      = acc_out_q[0];
    assign bus.acc1      = acc_out_q[1];
    assign bus.acc2      = acc_out_q[2];
    assign bus.acc3      = acc_out_q[3];
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = out_valid_q;

endmodule
